univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register: the multi-bit, multi-mode successor to the
//  single-bit D flip-flop. Holds, shifts left or right, rotates, or parallel-loads
//  a WIDTH-bit word on one clock. Serves as the serialiser/deserialiser and
//  barrel-rotate stage in the flip-flop library.
//  A shift counter reports when every bit of the last loaded word has been shifted out.
// PARAMETERS
//  WIDTH    8      register width in bits; legal range WIDTH >= 2
//  RST_VAL  0      value Q takes on reset, WIDTH bits wide
// PORTS
//  clk       in   1          single clock; all state updates on the rising edge
//  rst       in   1          synchronous reset, active-high
//  en        in   1          clock enable; 0 = hold everything
//  mode      in   2          00 hold, 01 shift right, 10 shift left, 11 parallel load
//  rotate    in   1          1 = recirculate the exiting bit instead of serial input
//  ser_msb   in   1          serial fill bit entering Q[WIDTH-1] on a right shift
//  ser_lsb   in   1          serial fill bit entering Q[0] on a left shift
//  D         in   WIDTH      parallel load data
//  Q         out  WIDTH      register contents
//  sout_r    out  1          Q[0]: bit that leaves on the next right shift
//  sout_l    out  1          Q[WIDTH-1]: bit that leaves on the next left shift
//  shift_cnt out  CW         shifts since last load or reset, CW = $clog2(WIDTH+1)
//  drained   out  1          1 when shift_cnt == WIDTH
// BEHAVIOUR
//  - Reset is synchronous and active-high; it is sampled only at a rising clk edge
//    and has priority over en and mode.
//  - Reset values: Q=RST_VAL, shift_cnt=0, drained=0.
//  - sout_r, sout_l and drained are combinational decodes of registered state, so
//    they carry no additional latency.
//  - All other updates take one cycle: the new value appears after the edge that
//    samples the inputs.
//  - en=0: Q and shift_cnt hold, regardless of mode, rotate or D.
//  - en=1, mode=00: hold. Q and shift_cnt are unchanged.
//  - en=1, mode=01 (shift right): Q <= {fill, Q[WIDTH-1:1]}.
//    fill = rotate ? Q[0] : ser_msb.
//  - en=1, mode=10 (shift left): Q <= {Q[WIDTH-2:0], fill}.
//    fill = rotate ? Q[WIDTH-1] : ser_lsb.
//  - en=1, mode=11 (load): Q <= D and shift_cnt <= 0. rotate, ser_msb and ser_lsb
//    are ignored.
//  - shift_cnt increments on every enabled shift, rotating or not, in either
//    direction. It saturates at WIDTH and never wraps.
//  - A reset or load issued mid-sequence aborts the sequence. The next edge applies
//    reset or load values, and any partial shift state is discarded.
//  - Mixed left and right shifts all count; no direction tracking is kept.
//  - X or undefined inputs are not handled: the mode decode is full-case with no
//    default state.
// TESTING
//  1. Reset priority: rst=1, en=1, mode=11, D=8'hFF for 3 edges.
//     -> Q=8'h00, shift_cnt=0, drained=0.
//  2. Right-shift drain: load 8'hA5, then 8 right shifts with ser_msb=0, rotate=0.
//     -> sout_r before each edge reads 1,0,1,0,0,1,0,1.
//     -> Final Q=8'h00, drained=1; a 9th shift leaves shift_cnt=8.
//  3. Left rotate: load 8'h81, then rotate-left with rotate=1.
//     -> Q=8'h03 after 1 edge, 8'h81 after 8 edges, drained=1.
//  4. Enable gating: load 8'h3C, then en=0 with mode=01 for 4 edges.
//     -> Q=8'h3C, shift_cnt=0.
//  5. Abort mid-shift: load 8'hF0 and shift right 3 (Q=8'h1E, cnt=3).
//     -> A load of 8'h55 gives Q=8'h55, cnt=0.
//     -> rst on the next edge gives Q=8'h00, cnt=0.
//  6. Serial fill: from 8'h00, 4 left shifts with ser_lsb=1.
//     -> Q=8'h0F, shift_cnt=4, drained=0.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for the universal shift register: the master drives
// mode, serial fill and load data; the slave returns the register state.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             rotate;
  logic             ser_msb;
  logic             ser_lsb;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    shift_cnt;
  logic             drained;

  modport master (
    output en, mode, rotate, ser_msb, ser_lsb, D,
    input  Q, sout_r, sout_l, shift_cnt, drained
  );

  modport slave (
    input  en, mode, rotate, ser_msb, ser_lsb, D,
    output Q, sout_r, sout_l, shift_cnt, drained
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left with serial fill or rotate,
// parallel load; a saturating counter reports when the loaded word has drained.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  univ_shift_reg_if.slave  bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_q_p0;
  logic [CW-1:0]    r_cnt_p0;
  logic             w_fill_r;
  logic             w_fill_l;

  // Counter stops at WIDTH so drained stays asserted through extra shifts.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  assign w_fill_r = bus.rotate ? r_q_p0[0]       : bus.ser_msb;
  assign w_fill_l = bus.rotate ? r_q_p0[WIDTH-1] : bus.ser_lsb;

  // Stage p0: register and shift counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_p0   <= RST_VAL;
      r_cnt_p0 <= '0;
    end else if (bus.en) begin
      case (bus.mode)
        2'b00: begin
          r_q_p0   <= r_q_p0;
          r_cnt_p0 <= r_cnt_p0;
        end
        2'b01: begin
          r_q_p0   <= {w_fill_r, r_q_p0[WIDTH-1:1]};
          r_cnt_p0 <= sat_inc(r_cnt_p0);
        end
        2'b10: begin
          r_q_p0   <= {r_q_p0[WIDTH-2:0], w_fill_l};
          r_cnt_p0 <= sat_inc(r_cnt_p0);
        end
        2'b11: begin
          r_q_p0   <= bus.D;
          r_cnt_p0 <= '0;
        end
      endcase
    end
  end

  assign bus.Q         = r_q_p0;
  assign bus.sout_r    = r_q_p0[0];
  assign bus.sout_l    = r_q_p0[WIDTH-1];
  assign bus.shift_cnt = r_cnt_p0;
  assign bus.drained   = (r_cnt_p0 == CNT_MAX);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): reset priority, drain, rotate,
// enable gating, abort, serial fill and hold.
module tb_univ_shift_reg;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic rot,
                       input logic smsb, input logic slsb, input logic [7:0] d);
    bus.en = en; bus.mode = mode; bus.rotate = rot;
    bus.ser_msb = smsb; bus.ser_lsb = slsb; bus.D = d;
  endtask

  task automatic do_load(input logic [7:0] d);
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, d);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h want=00", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", bus.shift_cnt); end
    n_cmp++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL reset_drained got=%b want=0", bus.drained); end
  endtask

  task automatic test_right_drain();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;
    do_load(8'hA5);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.sout_r !== exp_bits[i]) begin
        n_err++; $display("FAIL drain_sout_r[%0d] got=%b want=%b", i, bus.sout_r, exp_bits[i]);
      end
      tick();
    end
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL drain_q got=%h want=00", bus.Q); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL drain_drained got=%b want=1", bus.drained); end
    tick();
    n_cmp++; if (bus.shift_cnt !== 4'd8) begin n_err++; $display("FAIL drain_sat_cnt got=%0d want=8", bus.shift_cnt); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL drain_sat_drained got=%b want=1", bus.drained); end
  endtask

  task automatic test_left_rotate();
    do_load(8'h81);
    n_cmp++; if (bus.sout_l !== 1'b1) begin n_err++; $display("FAIL rotl_sout_l got=%b want=1", bus.sout_l); end
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.Q !== 8'h03) begin n_err++; $display("FAIL rotl_q1 got=%h want=03", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd1) begin n_err++; $display("FAIL rotl_cnt1 got=%0d want=1", bus.shift_cnt); end
    repeat (7) tick();
    n_cmp++; if (bus.Q !== 8'h81) begin n_err++; $display("FAIL rotl_q8 got=%h want=81", bus.Q); end
    n_cmp++; if (bus.drained !== 1'b1) begin n_err++; $display("FAIL rotl_drained got=%b want=1", bus.drained); end
  endtask

  task automatic test_right_rotate_fill();
    do_load(8'h01);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.Q !== 8'h80) begin n_err++; $display("FAIL rotr_q got=%h want=80", bus.Q); end
    do_load(8'h00);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.Q !== 8'h80) begin n_err++; $display("FAIL fill_msb_q got=%h want=80", bus.Q); end
    // Mixed direction: one right then one left both count
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL mixed_q got=%h want=00", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd2) begin n_err++; $display("FAIL mixed_cnt got=%0d want=2", bus.shift_cnt); end
  endtask

  task automatic test_enable();
    do_load(8'h3C);
    drive(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 8'h00);
    repeat (4) tick();
    n_cmp++; if (bus.Q !== 8'h3C) begin n_err++; $display("FAIL en_q got=%h want=3C", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL en_cnt got=%0d want=0", bus.shift_cnt); end
    drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 8'hAA);
    tick();
    n_cmp++; if (bus.Q !== 8'h3C) begin n_err++; $display("FAIL en_load_q got=%h want=3C", bus.Q); end
  endtask

  task automatic test_hold();
    do_load(8'h96);
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 8'hFF);
    repeat (3) tick();
    n_cmp++; if (bus.Q !== 8'hCB) begin n_err++; $display("FAIL hold_q got=%h want=CB", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd1) begin n_err++; $display("FAIL hold_cnt got=%0d want=1", bus.shift_cnt); end
  endtask

  task automatic test_abort();
    do_load(8'hF0);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    n_cmp++; if (bus.Q !== 8'h1E) begin n_err++; $display("FAIL abort_shift_q got=%h want=1E", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd3) begin n_err++; $display("FAIL abort_shift_cnt got=%0d want=3", bus.shift_cnt); end
    do_load(8'h55);
    n_cmp++; if (bus.Q !== 8'h55) begin n_err++; $display("FAIL abort_load_q got=%h want=55", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL abort_load_cnt got=%0d want=0", bus.shift_cnt); end
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL abort_rst_q got=%h want=00", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd0) begin n_err++; $display("FAIL abort_rst_cnt got=%0d want=0", bus.shift_cnt); end
  endtask

  task automatic test_serial_fill();
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (4) tick();
    n_cmp++; if (bus.Q !== 8'h0F) begin n_err++; $display("FAIL fill_lsb_q got=%h want=0F", bus.Q); end
    n_cmp++; if (bus.shift_cnt !== 4'd4) begin n_err++; $display("FAIL fill_lsb_cnt got=%0d want=4", bus.shift_cnt); end
    n_cmp++; if (bus.drained !== 1'b0) begin n_err++; $display("FAIL fill_lsb_drained got=%b want=0", bus.drained); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    test_reset();
    test_right_drain();
    test_left_rotate();
    test_right_rotate_fill();
    test_enable();
    test_hold();
    test_abort();
    test_serial_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
